matvec_row_scheduler: RTL and testbench

Control block that computes an L×M by M×1 matrix–vector product by issuing one row at a time to a single shared 32-bit IEEE-754 dot-product engine. It latches the operands, masks each row to the runtime length, launches the engine through a start/done handshake, and collects the scalars into a result vector. It sits between a layer controller, which supplies start, dimensions and operands, and the vector multiplier that owns the arithmetic.

---
 rtl/matvec_row_scheduler_pkg.sv | 18 +
 rtl/vec_pad_mask.sv | 25 ++
 rtl/matvec_row_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_matvec_row_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matvec_row_scheduler_pkg.sv
// Shared definitions for the row-at-a-time matrix-vector scheduler:
// word width, FSM state encoding and a few IEEE-754 constants.
package matvec_row_scheduler_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // Single-precision constants handy for stimulus
  localparam logic [WORD_W-1:0] FP_ONE = 32'h3F80_0000;
  localparam logic [WORD_W-1:0] FP_TWO = 32'h4000_0000;

endpackage

// File: rtl/vec_pad_mask.sv
// Zeroes every word of a packed vector whose index is >= len.
// Ports:
//   vec      - MBUF packed 32-bit words, word i at bits [i*32 +: 32]
//   len      - runtime length; words at index >= len are forced to 0
//   masked_c - combinational masked copy of vec
module vec_pad_mask
  import matvec_row_scheduler_pkg::*;
#(
  parameter int unsigned MBUF = 3
) (
  input  logic [WORD_W*MBUF-1:0] vec,
  input  logic [WORD_W-1:0]      len,
  output logic [WORD_W*MBUF-1:0] masked_c
);

  always_comb begin
    masked_c = '0;
    for (int unsigned i = 0; i < MBUF; i++) begin
      if (WORD_W'(i) < len) begin
        masked_c[i*WORD_W +: WORD_W] = vec[i*WORD_W +: WORD_W];
      end
    end
  end

endmodule

// File: rtl/matvec_row_scheduler.sv
// Issues one matrix row at a time to a shared dot-product engine and
// gathers the scalars into a result vector.
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   start, l, m      - request and runtime dimensions (sampled in IDLE)
//   A, x             - row-major matrix and input vector (latched on accept)
//   dp_a, dp_b       - masked operand vectors to the engine
//   dp_vlen          - latched column count
//   dp_start         - one-cycle launch pulse
//   dp_done          - one-cycle completion pulse, dp_result valid with it
//   result           - word i holds the row i dot product
//   busy, done, err  - status; err is sticky until the next accepted start
module matvec_row_scheduler
  import matvec_row_scheduler_pkg::*;
#(
  parameter int unsigned LBUF    = 3,
  parameter int unsigned MBUF    = 3,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [WORD_W-1:0]             l,
  input  logic [WORD_W-1:0]             m,
  input  logic [WORD_W*LBUF*MBUF-1:0]   A,
  input  logic [WORD_W*MBUF-1:0]        x,
  output logic [WORD_W*MBUF-1:0]        dp_a,
  output logic [WORD_W*MBUF-1:0]        dp_b,
  output logic [WORD_W-1:0]             dp_vlen,
  output logic                          dp_start,
  input  logic                          dp_done,
  input  logic [WORD_W-1:0]             dp_result,
  output logic [WORD_W*LBUF-1:0]        result,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int unsigned ROW_W = $clog2(LBUF + 1);
  localparam int unsigned VEC_W = WORD_W * MBUF;
  localparam int unsigned MAT_W = WORD_W * LBUF * MBUF;
  localparam int unsigned WD_W  = $clog2(TIMEOUT) + 1;

  state_t               state_q, state_d;
  logic [ROW_W-1:0]     row_q, row_d, row_inc;
  logic [WORD_W-1:0]    l_q, l_d, m_q, m_d;
  logic [MAT_W-1:0]     a_q, a_d;
  logic [VEC_W-1:0]     x_q, x_d;
  logic [WD_W-1:0]      wdog_q, wdog_d;

  logic [VEC_W-1:0]     dp_a_d, dp_b_d;
  logic [WORD_W-1:0]    dp_vlen_d;
  logic                 dp_start_d, busy_d, done_d, err_d;
  logic [WORD_W*LBUF-1:0] result_d;

  logic [VEC_W-1:0]     row_src, x_src, a_pad_c, x_pad_c;
  logic [WORD_W-1:0]    len_src;
  logic                 dims_ok;

  assign row_inc = row_q + ROW_W'(1);
  assign dims_ok = (l != '0) && (l <= 32'(LBUF)) && (m != '0) && (m <= 32'(MBUF));

  // Operands are registered on the edge that enters ISSUE: on acceptance the
  // first row comes straight from the inputs, afterwards from the latched copy.
  always_comb begin
    if (state_q == ST_IDLE) begin
      row_src = A[VEC_W-1:0];
      x_src   = x;
      len_src = m;
    end else begin
      row_src = a_q[32'(row_inc)*VEC_W +: VEC_W];
      x_src   = x_q;
      len_src = m_q;
    end
  end

  vec_pad_mask #(.MBUF(MBUF)) u_mask_a (
    .vec      (row_src),
    .len      (len_src),
    .masked_c (a_pad_c)
  );

  vec_pad_mask #(.MBUF(MBUF)) u_mask_x (
    .vec      (x_src),
    .len      (len_src),
    .masked_c (x_pad_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    l_d        = l_q;
    m_d        = m_q;
    a_d        = a_q;
    x_d        = x_q;
    wdog_d     = wdog_q;
    dp_a_d     = dp_a;
    dp_b_d     = dp_b;
    dp_vlen_d  = dp_vlen;
    dp_start_d = 1'b0;
    result_d   = result;
    done_d     = 1'b0;
    err_d      = err;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (dims_ok) begin
            l_d        = l;
            m_d        = m;
            a_d        = A;
            x_d        = x;
            row_d      = '0;
            result_d   = '0;
            err_d      = 1'b0;
            dp_vlen_d  = m;
            dp_a_d     = a_pad_c;
            dp_b_d     = x_pad_c;
            dp_start_d = 1'b1;
            state_d    = ST_ISSUE;
          end else begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_FIN;
          end
        end
      end
      ST_ISSUE: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion in the expiry cycle takes priority over the watchdog
        if (dp_done) begin
          result_d[32'(row_q)*WORD_W +: WORD_W] = dp_result;
          if (32'(row_q) == l_q - 32'd1) begin
            done_d  = 1'b1;
            state_d = ST_FIN;
          end else begin
            row_d      = row_inc;
            dp_a_d     = a_pad_c;
            dp_b_d     = x_pad_c;
            dp_start_d = 1'b1;
            state_d    = ST_ISSUE;
          end
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_FIN;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      l_q      <= '0;
      m_q      <= '0;
      a_q      <= '0;
      x_q      <= '0;
      wdog_q   <= '0;
      dp_a     <= '0;
      dp_b     <= '0;
      dp_vlen  <= '0;
      dp_start <= 1'b0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      l_q      <= l_d;
      m_q      <= m_d;
      a_q      <= a_d;
      x_q      <= x_d;
      wdog_q   <= wdog_d;
      dp_a     <= dp_a_d;
      dp_b     <= dp_b_d;
      dp_vlen  <= dp_vlen_d;
      dp_start <= dp_start_d;
      result   <= result_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_matvec_row_scheduler.sv
// Bench for matvec_row_scheduler: table of directed jobs run against a small
// integer-valued float engine model, plus noise and mid-job reset sequences.
`timescale 1ns/1ps
module tb_matvec_row_scheduler;
  import matvec_row_scheduler_pkg::*;

  localparam int unsigned LBUF    = 3;
  localparam int unsigned MBUF    = 3;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned VEC_W   = 32 * MBUF;
  localparam int unsigned RES_W   = 32 * LBUF;
  localparam int unsigned NVEC    = 10;

  localparam logic [31:0] F0 = 32'h0000_0000;
  localparam logic [31:0] F1 = FP_ONE;
  localparam logic [31:0] F2 = FP_TWO;
  localparam logic [31:0] F3 = 32'h4040_0000;
  localparam logic [31:0] F4 = 32'h4080_0000;
  localparam logic [31:0] F5 = 32'h40A0_0000;
  localparam logic [31:0] F6 = 32'h40C0_0000;
  localparam logic [31:0] F7 = 32'h40E0_0000;
  localparam logic [31:0] F8 = 32'h4100_0000;
  localparam logic [31:0] F9 = 32'h4110_0000;

  logic                   clk;
  logic                   rst, start;
  logic [31:0]            l, m;
  logic [32*LBUF*MBUF-1:0] A;
  logic [VEC_W-1:0]       x;
  logic [VEC_W-1:0]       dp_a, dp_b;
  logic [31:0]            dp_vlen;
  logic                   dp_start;
  logic                   dp_done;
  logic [31:0]            dp_result;
  logic [RES_W-1:0]       result;
  logic                   busy, done, err;

  matvec_row_scheduler #(.LBUF(LBUF), .MBUF(MBUF), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .l(l), .m(m), .A(A), .x(x),
    .dp_a(dp_a), .dp_b(dp_b), .dp_vlen(dp_vlen), .dp_start(dp_start),
    .dp_done(dp_done), .dp_result(dp_result), .result(result),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc;
  initial begin
    cyc = 0;
    forever @(posedge clk) cyc++;
  end

  // ---------------- helpers ----------------
  int unsigned n_chk, n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] mk3(input logic [31:0] w0, input logic [31:0] w1,
                                      input logic [31:0] w2);
    return {w2, w1, w0};
  endfunction

  // Small non-negative integral floats only
  function automatic int unsigned fp_to_int(input logic [31:0] b);
    int e;
    logic [23:0] mant;
    if (b[30:0] == 31'd0) return 0;
    e    = int'(b[30:23]) - 127;
    mant = {1'b1, b[22:0]};
    if (e < 0 || e > 23) return 0;
    return 32'(mant >> (23 - e));
  endfunction

  function automatic logic [31:0] int_to_fp(input int unsigned n);
    int p;
    logic [31:0] sh;
    if (n == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 24; i++) if (n[i]) p = i;
    sh = n << (23 - p);
    return {1'b0, 8'(p + 127), sh[22:0]};
  endfunction

  // ---------------- engine model ----------------
  int unsigned eng_d;
  logic        eng_on;
  logic        inject;
  logic [31:0] inject_val;

  initial begin
    int          eng_cnt;
    logic [31:0] eng_sum;
    int unsigned s;
    dp_done   = 1'b0;
    dp_result = 32'd0;
    eng_cnt   = 0;
    eng_sum   = 32'd0;
    forever begin
      @(negedge clk);
      dp_done = 1'b0;
      if (rst) begin
        eng_cnt = 0;
      end else begin
        if (eng_cnt > 0) begin
          eng_cnt--;
          if (eng_cnt == 0) begin
            dp_done   = 1'b1;
            dp_result = eng_sum;
          end
        end
        if (inject) begin
          dp_done   = 1'b1;
          dp_result = inject_val;
        end
        if (dp_start && eng_on) begin
          s = 0;
          for (int unsigned i = 0; i < MBUF; i++)
            s += fp_to_int(dp_a[i*32 +: 32]) * fp_to_int(dp_b[i*32 +: 32]);
          eng_sum = int_to_fp(s);
          eng_cnt = int'(eng_d);
        end
      end
    end
  end

  // ---------------- launch monitor ----------------
  int unsigned start_cyc[$];
  int unsigned pad_bad;
  int unsigned cur_m;

  initial begin
    pad_bad = 0;
    forever begin
      @(negedge clk);
      if (dp_start) begin
        start_cyc.push_back(cyc);
        if (dp_vlen != cur_m) pad_bad++;
        for (int unsigned i = 0; i < MBUF; i++)
          if (i >= cur_m && (dp_a[i*32 +: 32] != 32'd0 || dp_b[i*32 +: 32] != 32'd0))
            pad_bad++;
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    int unsigned              l, m;
    logic [32*LBUF*MBUF-1:0]  a;
    logic [VEC_W-1:0]         x;
    int unsigned              d;
    logic                     on;
    logic [RES_W-1:0]         res;
    logic                     err;
    int unsigned              done_cyc;
    int unsigned              starts;
  } vec_t;

  function automatic vec_t mkv(input int unsigned l_i, input int unsigned m_i,
                               input logic [95:0] r0, input logic [95:0] r1,
                               input logic [95:0] r2, input logic [95:0] x_i,
                               input int unsigned d_i, input logic on_i,
                               input logic [95:0] res_i, input logic err_i,
                               input int unsigned dc_i, input int unsigned st_i);
    vec_t v;
    v.l = l_i; v.m = m_i; v.a = {r2, r1, r0}; v.x = x_i; v.d = d_i; v.on = on_i;
    v.res = res_i; v.err = err_i; v.done_cyc = dc_i; v.starts = st_i;
    return v;
  endfunction

  vec_t tbl [NVEC];

  task automatic run_vec(input vec_t v, input logic noise, input int id);
    int unsigned base, pbase, t0, rel, done_rel, nst;
    logic        seen;
    base  = start_cyc.size();
    pbase = pad_bad;
    A = v.a; x = v.x; l = v.l; m = v.m;
    eng_d = v.d; eng_on = v.on; cur_m = v.m;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
    seen = 1'b0;
    done_rel = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      rel = cyc - t0 + 1;
      if (noise) begin
        start  = (rel == 2 || rel == 3 || rel == 7);
        inject = (rel == 5);
        if (rel == 2) begin
          A = '1; x = '1; l = 32'd1; m = 32'd1;
        end
      end
      if (done) begin
        seen = 1'b1;
        done_rel = rel;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    start  = 1'b0;
    inject = 1'b0;
    check($sformatf("v%0d_done_seen", id), 32'(seen), 32'd1);
    if (seen) begin
      check($sformatf("v%0d_done_cycle", id), done_rel, v.done_cyc);
      check($sformatf("v%0d_err", id), 32'(err), 32'(v.err));
      check($sformatf("v%0d_busy_at_done", id), 32'(busy), 32'd1);
      for (int unsigned i = 0; i < LBUF; i++)
        check($sformatf("v%0d_result%0d", id, i), result[i*32 +: 32], v.res[i*32 +: 32]);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", id), 32'(done), 32'd0);
      check($sformatf("v%0d_busy_after", id), 32'(busy), 32'd0);
    end
    nst = start_cyc.size() - base;
    check($sformatf("v%0d_num_starts", id), nst, v.starts);
    for (int unsigned j = 0; j < nst && j < v.starts; j++)
      check($sformatf("v%0d_start%0d_cycle", id, j),
            start_cyc[base + j] - t0 + 1, 1 + j * (v.d + 1));
    check($sformatf("v%0d_padding", id), pad_bad - pbase, 32'd0);
  endtask

  // ---------------- main ----------------
  initial begin
    int unsigned t0;
    n_chk = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; l = '0; m = '0; A = '0; x = '0;
    eng_d = 1; eng_on = 1'b1; inject = 1'b0; inject_val = 32'h42C8_0000; cur_m = 0;

    tbl[0] = mkv(2, 3, mk3(F1,F1,F1), mk3(F2,F2,F2), mk3(F0,F0,F0), mk3(F1,F1,F1),
                 3, 1'b1, mk3(F3,F6,F0), 1'b0, 9, 2);
    tbl[1] = mkv(3, 2, mk3(F1,F1,F5), mk3(F2,F1,F7), mk3(F2,F2,F3), mk3(F1,F2,F9),
                 1, 1'b1, mk3(F3,F4,F6), 1'b0, 7, 3);
    tbl[2] = mkv(1, 1, mk3(F2,F5,F5), mk3(F9,F9,F9), mk3(F9,F9,F9), mk3(F2,F3,F3),
                 2, 1'b1, mk3(F4,F0,F0), 1'b0, 4, 1);
    tbl[3] = mkv(4, 3, mk3(F1,F1,F1), mk3(F1,F1,F1), mk3(F1,F1,F1), mk3(F1,F1,F1),
                 1, 1'b1, mk3(F4,F0,F0), 1'b1, 1, 0);
    tbl[4] = mkv(3, 3, mk3(F1,F1,F1), mk3(F1,F2,F1), mk3(F2,F2,F2), mk3(F1,F1,F2),
                 2, 1'b1, mk3(F4,F5,F8), 1'b0, 10, 3);
    tbl[5] = mkv(0, 1, mk3(F1,F1,F1), mk3(F1,F1,F1), mk3(F1,F1,F1), mk3(F1,F1,F1),
                 1, 1'b1, mk3(F4,F5,F8), 1'b1, 1, 0);
    tbl[6] = mkv(1, 4, mk3(F1,F1,F1), mk3(F1,F1,F1), mk3(F1,F1,F1), mk3(F1,F1,F1),
                 1, 1'b1, mk3(F4,F5,F8), 1'b1, 1, 0);
    tbl[7] = mkv(1, 3, mk3(F1,F1,F1), mk3(F9,F9,F9), mk3(F9,F9,F9), mk3(F1,F2,F2),
                 8, 1'b1, mk3(F5,F0,F0), 1'b0, 10, 1);
    tbl[8] = mkv(2, 3, mk3(F1,F1,F1), mk3(F2,F2,F2), mk3(F0,F0,F0), mk3(F1,F1,F1),
                 1, 1'b0, mk3(F0,F0,F0), 1'b1, 10, 1);
    tbl[9] = mkv(3, 1, mk3(F2,F7,F7), mk3(F1,F7,F7), mk3(F2,F7,F7), mk3(F2,F7,F7),
                 1, 1'b1, mk3(F4,F2,F4), 1'b0, 7, 3);

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_dp_start", 32'(dp_start), 32'd0);
    check("rst_dp_vlen", dp_vlen, 32'd0);
    check("rst_dp_a", 32'(|dp_a), 32'd0);
    check("rst_dp_b", 32'(|dp_b), 32'd0);
    check("rst_result", 32'(|result), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < int'(NVEC); i++) run_vec(tbl[i], 1'b0, i);

    // Start pulses in WAIT, spurious dp_done in ISSUE, inputs changed mid-job
    run_vec(tbl[0], 1'b1, 100);

    // Reset in the WAIT of row 1, then a clean rerun
    A = tbl[0].a; x = tbl[0].x; l = tbl[0].l; m = tbl[0].m;
    eng_d = tbl[0].d; eng_on = 1'b1; cur_m = tbl[0].m;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
    while (cyc - t0 + 1 < 6) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_row0", result[31:0], F3);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_result", 32'(|result), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_result", 32'(|result), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    run_vec(tbl[0], 1'b0, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
